fu_mul_pipe: RTL and testbench
==============================

# fu_mul_pipe

Parametrised, fully pipelined integer multiply functional unit for the out-of-order core. Successor to the fixed 7-cycle, one-op-at-a-time multiply unit. Adds configurable width and latency, RISC-V MUL/MULH/MULHSU/MULHU modes, a valid/ready handshake with back-pressure, result-tag pass-through and flush. Accepts one operation per cycle and sits between the reservation stations and the common data bus arbiter.

## Interface
- XLEN, 32, operand and result width
- LATENCY, 7, cycles from accept to out_valid; legal range 2..16
- TAG_W, 4, width of the reservation-station / ROB tag carried alongside each op
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous kill of every in-flight op
- in_valid  in  1  request present
- in_ready  out  1  unit accepts the request this cycle
- op  in  2  operation, encoding from fu_mul_pkg
- a, b  in  XLEN  operands (rs1, rs2)
- tag  in  TAG_W  destination tag
- out_valid  out  1  result present
- out_ready  in  1  bus arbiter takes the result this cycle
- res  out  XLEN  result
- out_tag  out  TAG_W  tag of res
- busy  out  1  at least one op in flight, including the output stage

## Operation
- Accept: in_valid & in_ready at a rising edge.
- Sign extension to XLEN+1 bits:
  - a is signed for MULH and MULHSU.
  - b is signed for MULH only.
  - All other operands are zero-extended.
- Product: signed (2·XLEN+2) bits.
- Result select:
  - MUL: product[XLEN-1:0].
  - MULH, MULHSU, MULHU: product[2·XLEN-1:XLEN].
- Pipeline: LATENCY stages, each holding valid, tag, op-select and partial/complete product. The last stage is the output register driving out_valid, res and out_tag.
- Global stall condition: stall = out_valid & ~out_ready. While stall is asserted, every stage holds its contents.
- in_ready = ~stall & ~flush.
- Bubbles do not compress. A stalled pipeline keeps its gaps.
- flush:
  - Clears every stage valid bit, including out_valid, at the next edge.
  - Overrides stall.
  - A request on the flush cycle is not accepted.
- res and out_tag hold their last value while out_valid=0.
- busy = OR of all stage valid bits.

## Timing
- Reset values: out_valid=0, res=0, out_tag=0, busy=0, all stage valids 0. in_ready=1 once rst is deasserted (with out_valid=0 and flush=0).
- rst asserted mid-operation: all in-flight ops are discarded immediately (asynchronous). No output appears for them.
- Latency: an op accepted at edge N raises out_valid after edge N+LATENCY, provided no stall occurs in between. Each stalled cycle adds one cycle.
- Throughput: one op per cycle when out_ready=1 continuously.
- Handshake:
  - out_valid, res and out_tag stay stable until the cycle out_ready=1.
  - Ops leave in acceptance order.
- Simultaneous out_valid & out_ready & in_valid: the pipeline advances and the new op is accepted in the same edge.
- in_valid with in_ready=0: the request is not taken. The upstream must hold it.

## Structure
- fu_mul_pkg:
  - op encodings: MUL=2'd0, MULH=2'd1, MULHSU=2'd2, MULHU=2'd3.
  - helper functions op_a_signed(op), op_b_signed(op) and op_hi(op).
- One sub-module, mul_core:
  - Computes an (XLEN+1)×(XLEN+1) signed multiply, registered over LATENCY-1 stages, with a common enable input.
  - Retiming-friendly: the product computes in the first stage and shifts through the rest.
- The top level owns the handshake, valid/tag shift chain, flush, the output register and result select.

## Test plan
- Reset, then a=b=0xFFFFFFFF with each op at tag 1..4, out_ready=1 → results MUL=0x00000001, MULH=0x00000000, MULHSU=0xFFFFFFFF, MULHU=0xFFFFFFFE, in tag order. Each appears exactly 7 cycles after its accept.
- a=b=0x80000000 → MUL=0x00000000, MULH=0x40000000, MULHU=0x40000000. a=0x80000000, b=2 MULHSU → 0xFFFFFFFF.
- 20 back-to-back random ops with out_ready=1 → one result per cycle, matching the reference model, and in_ready never drops.
- Hold out_ready=0 for 10 cycles mid-stream → out_valid, res and out_tag stay stable, and in_ready=0. Releasing out_ready resumes with no loss or duplication and gaps preserved.
- Pulse flush with 5 ops in flight plus a concurrent in_valid → no outputs for any of them. busy=0 and out_valid=0 on the next cycle. The next op is accepted normally.
- Assert rst asynchronously (between edges) with ops in flight → out_valid and busy drop immediately and res=0. Rebuild the unit with XLEN=16, LATENCY=3 and rerun the first scenario scaled to 16 bits (0xFFFF operands).

Source files
------------

// File: rtl/fu_mul_pkg.sv
// fu_mul_pkg: multiply op encodings and operand-sign / result-half helpers
package fu_mul_pkg;
  typedef enum logic [1:0] {MUL = 2'd0, MULH = 2'd1, MULHSU = 2'd2, MULHU = 2'd3} mul_op_e;
  function automatic logic op_a_signed(logic [1:0] op);
    return op == MULH || op == MULHSU;
  endfunction
  function automatic logic op_b_signed(logic [1:0] op);
    return op == MULH;
  endfunction
  function automatic logic op_hi(logic [1:0] op);
    return op != MUL;
  endfunction
endpackage

// File: rtl/mul_core.sv
// mul_core: W x W signed multiply formed in the first stage, then shifted through STAGES-1 registers
module mul_core #(
  parameter int W      = 33,
  parameter int STAGES = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic [2*W-1:0] p_o
);
  logic [2*W-1:0] p_q [STAGES];
  // sign-extending both operands to 2W makes the truncated unsigned product the exact signed product
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < STAGES; i++) p_q[i] <= '0;
    else if (en_i) begin
      p_q[0] <= {{W{a_i[W-1]}}, a_i} * {{W{b_i[W-1]}}, b_i};
      for (int i = 1; i < STAGES; i++) p_q[i] <= p_q[i-1];
    end
  assign p_o = p_q[STAGES-1];
endmodule

// File: rtl/fu_mul_pipe.sv
// fu_mul_pipe: pipelined RISC-V MUL/MULH/MULHSU/MULHU unit with valid/ready, tag pass-through and flush
module fu_mul_pipe
  import fu_mul_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int LATENCY = 7,
  parameter int TAG_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [XLEN-1:0]  a,
  input  logic [XLEN-1:0]  b,
  input  logic [TAG_W-1:0] tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  res,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);
  localparam int W = XLEN + 1;
  logic               stall, en, load, unused;
  logic [LATENCY-1:0] v_q, v_d, hi_q;
  logic [TAG_W-1:0]   tag_q [LATENCY];
  logic [W-1:0]       a_q, b_q;
  logic [2*W-1:0]     prod;
  logic               out_valid_q, out_valid_d;
  logic [XLEN-1:0]    res_q, res_d;
  logic [TAG_W-1:0]   out_tag_q;
  assign stall    = out_valid_q & ~out_ready;
  assign en       = ~stall;
  assign in_ready = ~stall & ~flush;
  // the output register only reloads on a real op so res/out_tag hold across bubbles and flushes
  assign load     = en & ~flush & v_q[LATENCY-1];
  always_comb begin
    v_d         = flush ? '0 : en ? {v_q[LATENCY-2:0], in_valid & in_ready} : v_q;
    out_valid_d = flush ? 1'b0 : en ? v_q[LATENCY-1] : out_valid_q;
    res_d       = hi_q[LATENCY-1] ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      v_q         <= '0;
      hi_q        <= '0;
      for (int i = 0; i < LATENCY; i++) tag_q[i] <= '0;
      a_q         <= '0;
      b_q         <= '0;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      out_tag_q   <= '0;
    end else begin
      v_q         <= v_d;
      out_valid_q <= out_valid_d;
      if (en) begin
        hi_q     <= {hi_q[LATENCY-2:0], op_hi(op)};
        tag_q[0] <= tag;
        for (int i = 1; i < LATENCY; i++) tag_q[i] <= tag_q[i-1];
        a_q      <= {op_a_signed(op) & a[XLEN-1], a};
        b_q      <= {op_b_signed(op) & b[XLEN-1], b};
      end
      if (load) begin
        res_q     <= res_d;
        out_tag_q <= tag_q[LATENCY-1];
      end
    end
  mul_core #(.W(W), .STAGES(LATENCY-1)) u_core (
    .clk  (clk),
    .rst  (rst),
    .en_i (en),
    .a_i  (a_q),
    .b_i  (b_q),
    .p_o  (prod)
  );
  assign unused    = ^prod[2*W-1:2*XLEN];
  assign out_valid = out_valid_q;
  assign res       = res_q;
  assign out_tag   = out_tag_q;
  assign busy      = |v_q | out_valid_q;
endmodule

// File: tb/tb_fu_mul_pipe.sv
// tb_fu_mul_pipe: scoreboard bench for fu_mul_pipe at 32/7 and 16/3
module tb_fu_mul_pipe;
  localparam int LAT = 7, LAT2 = 3;
  typedef struct { logic [31:0] res; logic [3:0] tag; int c; } exp_t;
  logic clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 1;
  logic in_ready, out_valid, busy;
  logic [1:0] op = 0;
  logic [31:0] a = 0, b = 0, res;
  logic [3:0] tag = 0, out_tag;
  logic flush2 = 0, in_valid2 = 0, out_ready2 = 1, in_ready2, out_valid2, busy2;
  logic [1:0] op2 = 0;
  logic [15:0] a2 = 0, b2 = 0, res2;
  logic [3:0] tag2 = 0, out_tag2;
  exp_t sb[$], q2[$];
  int errors = 0, checks = 0, cyc = 0, waits = 0;
  bit lat_on = 0;
  logic [31:0] cur_exp = 0, exp2 = 0, hr;
  logic [3:0] ht;
  logic [1:0] ro;
  logic [31:0] rx, ry;
  logic [31:0] e16 [4] = '{32'h1, 32'h0, 32'hFFFF, 32'hFFFE};
  always #5 clk = ~clk;
  fu_mul_pipe #(.XLEN(32), .LATENCY(LAT), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .tag(tag), .out_valid(out_valid), .out_ready(out_ready), .res(res),
    .out_tag(out_tag), .busy(busy));
  fu_mul_pipe #(.XLEN(16), .LATENCY(LAT2), .TAG_W(4)) dut16 (
    .clk(clk), .rst(rst), .flush(flush2), .in_valid(in_valid2), .in_ready(in_ready2), .op(op2),
    .a(a2), .b(b2), .tag(tag2), .out_valid(out_valid2), .out_ready(out_ready2), .res(res2),
    .out_tag(out_tag2), .busy(busy2));
  task automatic check(input string t, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", t, got, exp, cyc);
    end
  endtask
  function automatic logic [31:0] ref_mul(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input int w);
    logic [63:0] m, p, h;
    longint sx, sy;
    m = (64'd1 << w) - 64'd1;
    sx = longint'(x & m[31:0]);
    sy = longint'(y & m[31:0]);
    if ((o == 2'd1 || o == 2'd2) && x[w-1]) sx -= longint'(1) << w;
    if (o == 2'd1 && y[w-1]) sy -= longint'(1) << w;
    p = sx * sy;
    h = (p >> w) & m;
    return o == 2'd0 ? (p[31:0] & m[31:0]) : h[31:0];
  endfunction
  // samples 1 time unit before each rising edge, i.e. exactly what that edge will see
  always @(negedge clk) begin
    exp_t e;
    #4;
    cyc++;
    if (rst) begin
      sb.delete();
      q2.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) check("spurious_out", out_valid, 0);
        else begin
          e = sb.pop_front();
          check("res", res, e.res);
          check("out_tag", out_tag, e.tag);
          if (lat_on) check("latency", cyc - e.c, LAT + 1);
        end
      end
      if (flush) sb.delete();
      else if (in_valid && in_ready) sb.push_back('{cur_exp, tag, cyc});
      if (out_valid2 && out_ready2) begin
        if (q2.size() == 0) check("spurious_out16", out_valid2, 0);
        else begin
          e = q2.pop_front();
          check("res16", {16'd0, res2}, e.res);
          check("out_tag16", out_tag2, e.tag);
          check("latency16", cyc - e.c, LAT2 + 1);
        end
      end
      if (in_valid2 && in_ready2) q2.push_back('{exp2, tag2, cyc});
    end
  end
  task automatic send(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input logic [3:0] t, input logic [31:0] e);
    logic ok;
    ok = 0;
    op = o; a = x; b = y; tag = t; cur_exp = e; in_valid = 1; waits = 0;
    for (int n = 0; n < 200; n++) begin
      #4 ok = in_ready;
      @(negedge clk);
      if (ok) break;
      waits++;
    end
    in_valid = 0;
    if (!ok) check("accept_timeout", in_ready, 1);
  endtask
  task automatic drain();
    for (int n = 0; n < 100 && (sb.size() != 0 || q2.size() != 0); n++) @(negedge clk);
    check("drain", sb.size(), 0);
    check("drain16", q2.size(), 0);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_res", res, 0);
    check("rst_out_tag", out_tag, 0);
    rst = 0;
    #1 check("rst_in_ready", in_ready, 1);
    @(negedge clk);
    lat_on = 1;
    send(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd1, 32'h00000001);
    send(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd2, 32'h00000000);
    send(2'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd3, 32'hFFFFFFFF);
    send(2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd4, 32'hFFFFFFFE);
    send(2'd0, 32'h80000000, 32'h80000000, 4'd5, 32'h00000000);
    send(2'd1, 32'h80000000, 32'h80000000, 4'd6, 32'h40000000);
    send(2'd3, 32'h80000000, 32'h80000000, 4'd7, 32'h40000000);
    send(2'd2, 32'h80000000, 32'h00000002, 4'd8, 32'hFFFFFFFF);
    drain();
    for (int i = 0; i < 20; i++) begin
      ro = 2'($urandom_range(0, 3)); rx = $urandom; ry = $urandom;
      send(ro, rx, ry, 4'(i), ref_mul(ro, rx, ry, 32));
      check("in_ready_b2b", waits, 0);
    end
    drain();
    lat_on = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          ro = 2'($urandom_range(0, 3)); rx = $urandom; ry = $urandom;
          send(ro, rx, ry, 4'(i), ref_mul(ro, rx, ry, 32));
          @(negedge clk);
        end
      end
      begin
        for (int n = 0; n < 50 && !out_valid; n++) @(negedge clk);
        out_ready = 0; hr = res; ht = out_tag;
        repeat (10) begin
          @(negedge clk);
          check("stall_valid", out_valid, 1);
          check("stall_res", res, hr);
          check("stall_tag", out_tag, ht);
          check("stall_in_ready", in_ready, 0);
        end
        out_ready = 1;
      end
    join
    drain();
    for (int i = 0; i < 5; i++) send(2'd0, 32'(i + 3), 32'd7, 4'(10 + i), 32'(7 * (i + 3)));
    flush = 1; op = 2'd0; a = 32'd3; b = 32'd5; tag = 4'd15; in_valid = 1;
    #1 check("flush_in_ready", in_ready, 0);
    @(negedge clk);
    flush = 0; in_valid = 0;
    check("flush_busy", busy, 0);
    check("flush_out_valid", out_valid, 0);
    repeat (12) @(negedge clk);
    send(2'd0, 32'd3, 32'd5, 4'd15, 32'd15);
    drain();
    out_ready = 0;
    for (int i = 0; i < 3; i++) send(2'd3, 32'(i), 32'd9, 4'(i), 32'd0);
    repeat (8) @(negedge clk);
    check("pre_rst_valid", out_valid, 1);
    #2 rst = 1;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_res", res, 0);
    @(negedge clk);
    rst = 0; out_ready = 1;
    repeat (10) @(negedge clk);
    check("post_rst_busy", busy, 0);
    for (int i = 0; i < 4; i++) begin
      in_valid2 = 1; op2 = 2'(i); a2 = 16'hFFFF; b2 = 16'hFFFF; tag2 = 4'(i + 1); exp2 = e16[i];
      @(negedge clk);
    end
    in_valid2 = 0;
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end
endmodule
